// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised Moore sequence detector with KMP transitions and saturating match counter
module seq_detector_param #(
   parameter int               LEN     = 3,
   parameter logic [LEN-1:0]   PATTERN = 3'b001,
   parameter bit               OVERLAP = 1'b1,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             in,
   input  logic             cnt_clr,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int SW = $clog2(LEN + 1);
   localparam int NS = 2 ** SW;
   localparam logic [SW-1:0] L_MATCH = SW'(LEN);

   // Reject pattern lengths the state encoding and table builder are not meant for.
   if (LEN < 1 || LEN > 16) begin : g_len_chk
      $error("seq_detector_param: LEN must be in 1..16");
   end
   if (CNT_W < 1) begin : g_cnt_chk
      $error("seq_detector_param: CNT_W must be at least 1");
   end

   // Bit i of the sequence "first k pattern bits followed by b" (index 0 = oldest).
   function automatic bit f_seq_bit(input int k, input bit b, input int i);
      bit r;
      if (i < k) r = PATTERN[LEN-1-i];
      else       r = b;
      return r;
   endfunction

   // Longest pattern prefix that is a suffix of (prefix_k, b); never longer than LEN.
   function automatic int f_next(input int k, input bit b);
      int  jmax;
      int  res;
      bit  found;
      bit  ok;
      jmax  = (k + 1 > LEN) ? LEN : k + 1;
      res   = 0;
      found = 1'b0;
      for (int j = jmax; j >= 1; j--) begin
         ok = 1'b1;
         for (int t = 0; t < j; t++) begin
            if (PATTERN[LEN-1-t] != f_seq_bit(k, b, k + 1 - j + t)) ok = 1'b0;
         end
         if (ok && !found) begin
            res   = j;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   // Without overlap the match state forgets the pattern and acts like the empty state.
   function automatic int f_trans(input int k, input bit b);
      int r;
      if (k == LEN && !OVERLAP) r = f_next(0, b);
      else                      r = f_next(k, b);
      return r;
   endfunction

   logic [SW-1:0]    r_state;
   logic [SW-1:0]    w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             w_hit;
   logic [SW-1:0]    w_tbl0 [NS];
   logic [SW-1:0]    w_tbl1 [NS];

   // Transition constants are fixed at elaboration; unreachable encodings fall back to 0.
   for (genvar gs = 0; gs < NS; gs++) begin : g_tbl
      if (gs <= LEN) begin : g_live
         localparam int N0 = f_trans(gs, 1'b0);
         localparam int N1 = f_trans(gs, 1'b1);
         assign w_tbl0[gs] = SW'(N0);
         assign w_tbl1[gs] = SW'(N1);
      end else begin : g_dead
         assign w_tbl0[gs] = '0;
         assign w_tbl1[gs] = '0;
      end
   end

   // State register: the length of the matched pattern prefix.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) r_state <= '0;
      else     r_state <= w_next;
   end

   // Next state: follow the precomputed transition only on accepted cycles.
   always_comb begin
      w_next = r_state;
      if (en) w_next = in ? w_tbl1[r_state] : w_tbl0[r_state];
   end

   // Moore output decoded from the registered state only.
   always_comb begin
      out = (r_state == L_MATCH);
   end

   assign w_hit = en && (w_next == L_MATCH);

   // Match counter: clear has priority over a simultaneous match, and it never wraps.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)                       r_cnt <= '0;
      else if (cnt_clr)              r_cnt <= '0;
      else if (w_hit && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
   end

   assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param across several parameter sets
module tb_seq_detector_param;

   localparam int NI = 7;

   typedef struct packed {
      logic [NI-1:0]   o;
      logic [NI*8-1:0] c;
   } exp_t;

   logic clk = 1'b0;
   logic clr = 1'b0;
   logic en  = 1'b0;
   logic din = 1'b0;
   logic cc  = 1'b0;

   logic [NI-1:0] w_o;
   logic [7:0]    c0, c1, c2, c4, c5;
   logic [1:0]    c3;
   logic [3:0]    c6;
   logic [NI*8-1:0] w_c;

   int n_checks = 0;
   int n_err    = 0;

   exp_t q[$];
   event ev_chk;

   // reference model state
   int          m_len  [NI] = '{3, 4, 4, 3, 3, 1, 16};
   logic [15:0] m_pat  [NI] = '{16'b001, 16'b1011, 16'b1011, 16'b111, 16'b111, 16'b0, 16'b1010_1010_1010_1010};
   bit          m_ov   [NI] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   int          m_max  [NI] = '{255, 255, 255, 3, 255, 255, 15};
   logic [15:0] m_hist [NI];
   int          m_since[NI];
   bit          m_out  [NI];
   int          m_cnt  [NI];

   always #5 clk = ~clk;

   seq_detector_param #(.LEN(3), .PATTERN(3'b001), .OVERLAP(1'b1), .CNT_W(8)) u0 (
      .clk(clk), .clr(clr), .en(en), .in(din), .cnt_clr(cc), .out(w_o[0]), .match_cnt(c0));
   seq_detector_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u1 (
      .clk(clk), .clr(clr), .en(en), .in(din), .cnt_clr(cc), .out(w_o[1]), .match_cnt(c1));
   seq_detector_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u2 (
      .clk(clk), .clr(clr), .en(en), .in(din), .cnt_clr(cc), .out(w_o[2]), .match_cnt(c2));
   seq_detector_param #(.LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1), .CNT_W(2)) u3 (
      .clk(clk), .clr(clr), .en(en), .in(din), .cnt_clr(cc), .out(w_o[3]), .match_cnt(c3));
   seq_detector_param #(.LEN(3), .PATTERN(3'b111), .OVERLAP(1'b0), .CNT_W(8)) u4 (
      .clk(clk), .clr(clr), .en(en), .in(din), .cnt_clr(cc), .out(w_o[4]), .match_cnt(c4));
   seq_detector_param #(.LEN(1), .PATTERN(1'b0), .OVERLAP(1'b1), .CNT_W(8)) u5 (
      .clk(clk), .clr(clr), .en(en), .in(din), .cnt_clr(cc), .out(w_o[5]), .match_cnt(c5));
   seq_detector_param #(.LEN(16), .PATTERN(16'b1010_1010_1010_1010), .OVERLAP(1'b1), .CNT_W(4)) u6 (
      .clk(clk), .clr(clr), .en(en), .in(din), .cnt_clr(cc), .out(w_o[6]), .match_cnt(c6));

   assign w_c = {4'b0, c6, c5, c4, 6'b0, c3, c2, c1, c0};

   // Model: a match is the last LEN accepted bits equalling the pattern; without overlap
   // those LEN bits must all arrive after the previous match.
   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m_hist[i]  = '0;
         m_since[i] = 0;
         m_out[i]   = 1'b0;
         m_cnt[i]   = 0;
      end
   endtask

   task automatic model_edge(input bit e, input bit b, input bit c);
      logic [15:0] mask;
      bit hit;
      for (int i = 0; i < NI; i++) begin
         hit = 1'b0;
         if (e) begin
            m_hist[i] = {m_hist[i][14:0], b};
            if (m_since[i] < 16) m_since[i]++;
            mask = (m_len[i] == 16) ? 16'hFFFF : ((16'(1) << m_len[i]) - 16'(1));
            hit = (m_since[i] >= m_len[i]) && ((m_hist[i] & mask) == m_pat[i]);
            if (hit && !m_ov[i]) m_since[i] = 0;
            m_out[i] = hit;
         end
         if (c)                               m_cnt[i] = 0;
         else if (hit && m_cnt[i] < m_max[i]) m_cnt[i]++;
      end
   endtask

   task automatic push_exp();
      exp_t x;
      for (int i = 0; i < NI; i++) begin
         x.o[i]       = m_out[i];
         x.c[i*8 +: 8] = 8'(m_cnt[i]);
      end
      q.push_back(x);
   endtask

   task automatic step(input bit b, input bit e, input bit c);
      @(negedge clk);
      din = b; en = e; cc = c;
      @(posedge clk);
      #1;
      model_edge(e, b, c);
      push_exp();
   endtask

   task automatic send_bits(input logic [31:0] bits, input int n);
      logic [31:0] v;
      v = bits;
      for (int k = n - 1; k >= 0; k--) step(v[k], 1'b1, 1'b0);
   endtask

   // Asynchronous reset between edges, checked immediately and again while held across an edge.
   task automatic async_clr();
      @(negedge clk);
      #2;
      clr = 1'b1;
      model_reset();
      push_exp();
      ->ev_chk;
      @(negedge clk);
      din = 1'b0; en = 1'b1; cc = 1'b0;
      @(posedge clk);
      #1;
      push_exp();
      @(negedge clk);
      clr = 1'b0;
      en  = 1'b0;
   endtask

   // Monitor: compare every queued expectation against the outputs the DUT presents.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or ev_chk);
         #2;
         while (q.size() > 0) begin
            e = q.pop_front();
            for (int i = 0; i < NI; i++) begin
               n_checks++;
               if (w_o[i] !== e.o[i]) begin
                  n_err++;
                  $display("FAIL u%0d.out t=%0t act=%0b exp=%0b", i, $time, w_o[i], e.o[i]);
               end
               n_checks++;
               if (w_c[i*8 +: 8] !== e.c[i*8 +: 8]) begin
                  n_err++;
                  $display("FAIL u%0d.match_cnt t=%0t act=%0d exp=%0d", i, $time, w_c[i*8 +: 8], e.c[i*8 +: 8]);
               end
            end
         end
      end
   end

   initial begin
      bit e, b, c;
      model_reset();
      repeat (2) @(posedge clk);
      async_clr();

      send_bits(32'b001001, 6);
      async_clr();
      send_bits(32'b1011011, 7);
      async_clr();
      send_bits(32'b111111, 6);
      async_clr();
      send_bits(32'b00, 2);
      repeat (3) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      async_clr();
      repeat (9) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      async_clr();
      send_bits(32'b00, 2);
      async_clr();
      send_bits(32'b1, 1);
      send_bits(32'b001, 3);
      async_clr();
      send_bits(32'b1010_1010_1010_1010_1010_1010, 24);
      repeat (2) step(1'b0, 1'b0, 1'b0);
      async_clr();

      for (int n = 0; n < 3000; n++) begin
         e = ($urandom % 4) != 0;
         b = ($urandom % 2) != 0;
         c = e && (($urandom % 50) == 0);
         if (($urandom % 400) == 0) async_clr();
         else                       step(b, e, c);
      end

      repeat (3) @(posedge clk);
      #4;
      n_checks++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain act=%0d exp=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
